// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the EX operand stage: field widths, writeback-select
// and forward-select encodings, and the ID/EX control/index payload.
package ex_operand_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned RES_SRC_W = 2;
    localparam int unsigned ALU_CTL_W = 3;
    localparam int unsigned FWD_SEL_W = 2;
    localparam int unsigned CNT_W     = 32;

    typedef enum logic [RES_SRC_W-1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } resultSrcT;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwdSelT;

    // Non-datapath part of the ID/EX register; all-zero is a bubble
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 regWrite;
        logic                 memWrite;
        logic                 aluSrc;
        logic                 branch;
        logic                 jump;
        logic [RES_SRC_W-1:0] resultSrc;
        logic [ALU_CTL_W-1:0] aluControl;
    } exCtrlT;

endpackage

// File: rtl/ex_operand_stage_fwd_mux3.sv
// Forwarding operand multiplexer: picks the register-file value, the MEM-stage
// ALU result or the WB result. The unused select code falls back to the
// register-file value.
//   sel  in  2      forward select (FWD_RF / FWD_MEM / FWD_WB)
//   rf   in  WIDTH  registered register-file read
//   mem  in  WIDTH  value forwarded from MEM
//   wb   in  WIDTH  value forwarded from WB
//   y    out WIDTH  selected operand (combinational)
module fwd_mux3
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [FWD_SEL_W-1:0] sel,
    input  logic [WIDTH-1:0]     rf,
    input  logic [WIDTH-1:0]     mem,
    input  logic [WIDTH-1:0]     wb,
    output logic [WIDTH-1:0]     y
);

    always_comb begin
        y = rf;
        case (sel)
            FWD_MEM: y = mem;
            FWD_WB:  y = wb;
            default: y = rf;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection, branch flush bubble
// insertion, operand forwarding muxes and optional hazard performance counters.
// Optional feature macro: PERF_CNT_EN (stall/flush counters; tied to 0 otherwise).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   validD, rs1D/rs2D/rdD, rd1D/rd2D,
//   immExtD, pcD, *D controls           decode-stage instruction fields
//   PCSrcE                              taken branch/jump resolved in EX
//   forwardAE/forwardBE                 forward selects from the forwarding unit
//   ALUResultM, ResultW                 forwarded values
//   *E outputs                          registered ID/EX contents
//   SrcAE, SrcBE, WriteDataE            ALU operands and store data
//   stallF, stallD, flushD              hazard controls to the front end
//   stallCnt, flushCnt                  hazard performance counters
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 validD,
    input  logic [REG_IDX_W-1:0] rs1D,
    input  logic [REG_IDX_W-1:0] rs2D,
    input  logic [REG_IDX_W-1:0] rdD,
    input  logic [XLEN-1:0]      rd1D,
    input  logic [XLEN-1:0]      rd2D,
    input  logic [XLEN-1:0]      immExtD,
    input  logic [XLEN-1:0]      pcD,
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 ALUSrcD,
    input  logic                 BranchD,
    input  logic                 JumpD,
    input  logic [RES_SRC_W-1:0] ResultSrcD,
    input  logic [ALU_CTL_W-1:0] ALUControlD,
    input  logic                 PCSrcE,
    input  logic [FWD_SEL_W-1:0] forwardAE,
    input  logic [FWD_SEL_W-1:0] forwardBE,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic [XLEN-1:0]      ResultW,
    output logic [REG_IDX_W-1:0] rs1E,
    output logic [REG_IDX_W-1:0] rs2E,
    output logic [REG_IDX_W-1:0] rdE,
    output logic                 validE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic [RES_SRC_W-1:0] ResultSrcE,
    output logic [ALU_CTL_W-1:0] ALUControlE,
    output logic [XLEN-1:0]      pcE,
    output logic [XLEN-1:0]      immExtE,
    output logic [XLEN-1:0]      SrcAE,
    output logic [XLEN-1:0]      SrcBE,
    output logic [XLEN-1:0]      WriteDataE,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 flushD,
    output logic [CNT_W-1:0]     stallCnt,
    output logic [CNT_W-1:0]     flushCnt
);

    exCtrlT          ctrlD;
    exCtrlT          ctrlE;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic            lwStall;
    logic            bubble;

    assign ctrlD = '{
        valid:      validD,
        rs1:        rs1D,
        rs2:        rs2D,
        rd:         rdD,
        regWrite:   RegWriteD,
        memWrite:   MemWriteD,
        aluSrc:     ALUSrcD,
        branch:     BranchD,
        jump:       JumpD,
        resultSrc:  ResultSrcD,
        aluControl: ALUControlD
    };

    // Load in EX whose destination is read by the instruction in decode;
    // a taken branch squashes decode anyway, so it takes priority.
    assign lwStall = (ctrlE.resultSrc == RES_LOAD) && ctrlE.valid
                     && (ctrlE.rd != '0)
                     && ((ctrlE.rd == rs1D) || (ctrlE.rd == rs2D))
                     && !PCSrcE;
    assign bubble  = lwStall || PCSrcE;

    assign stallF = lwStall;
    assign stallD = lwStall;
    assign flushD = PCSrcE;

    // ID/EX register; reset and bubbles both load all-zero
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ctrlE   <= '0;
            rd1E    <= '0;
            rd2E    <= '0;
            immExtE <= '0;
            pcE     <= '0;
        end else begin
            ctrlE   <= ctrlD;
            rd1E    <= rd1D;
            rd2E    <= rd2D;
            immExtE <= immExtD;
            pcE     <= pcD;
        end
    end

    assign validE      = ctrlE.valid;
    assign rs1E        = ctrlE.rs1;
    assign rs2E        = ctrlE.rs2;
    assign rdE         = ctrlE.rd;
    assign RegWriteE   = ctrlE.regWrite;
    assign MemWriteE   = ctrlE.memWrite;
    assign ALUSrcE     = ctrlE.aluSrc;
    assign BranchE     = ctrlE.branch;
    assign JumpE       = ctrlE.jump;
    assign ResultSrcE  = ctrlE.resultSrc;
    assign ALUControlE = ctrlE.aluControl;

    fwd_mux3 #(.WIDTH(XLEN)) u_muxA (
        .sel (forwardAE),
        .rf  (rd1E),
        .mem (ALUResultM),
        .wb  (ResultW),
        .y   (SrcAE)
    );

    fwd_mux3 #(.WIDTH(XLEN)) u_muxB (
        .sel (forwardBE),
        .rf  (rd2E),
        .mem (ALUResultM),
        .wb  (ResultW),
        .y   (WriteDataE)
    );

    assign SrcBE = ALUSrcE ? immExtE : WriteDataE;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stallCntQ;
    logic [CNT_W-1:0] flushCntQ;

    // Saturating hazard counters; reset wins over any event in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (lwStall && (stallCntQ != '1)) stallCntQ <= stallCntQ + CNT_W'(1);
            if (PCSrcE && (flushCntQ != '1))  flushCntQ <= flushCntQ + CNT_W'(1);
        end
    end

    assign stallCnt = stallCntQ;
    assign flushCnt = flushCntQ;
`else
    assign stallCnt = '0;
    assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage. Every driven cycle pushes the
// expected ID/EX contents and counter values; a monitor pops and compares them
// after each clock edge. Scenario tasks check hazard outputs and operand muxes.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            validD;
    logic [4:0]      rs1D, rs2D, rdD;
    logic [XLEN-1:0] rd1D, rd2D, immExtD, pcD;
    logic            RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic            PCSrcE;
    logic [1:0]      forwardAE, forwardBE;
    logic [XLEN-1:0] ALUResultM, ResultW;
    logic [4:0]      rs1E, rs2E, rdE;
    logic            validE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] pcE, immExtE, SrcAE, SrcBE, WriteDataE;
    logic            stallF, stallD, flushD;
    logic [31:0]     stallCnt, flushCnt;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        regWrite, memWrite, aluSrc, branch, jump;
        logic [1:0]  resSrc;
        logic [2:0]  aluCtl;
        logic [31:0] pc, imm, rd1, rd2;
    } eT;

    typedef struct {
        eT           e;
        logic [31:0] sc;
        logic [31:0] fc;
    } sbT;

    sbT          sb[$];
    sbT          ent;
    eT           modelE = '0;
    logic [31:0] expSc = '0;
    logic [31:0] expFc = '0;
    int          total = 0;
    int          bad = 0;

    ex_operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .validD(validD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .rd1D(rd1D), .rd2D(rd2D), .immExtD(immExtD), .pcD(pcD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .PCSrcE(PCSrcE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .validE(validE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .pcE(pcE), .immExtE(immExtE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: one expected entry per clock edge
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            total++;
            if ({validE, rs1E, rs2E, rdE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
                 ResultSrcE, ALUControlE, pcE, immExtE} !==
                {ent.e.valid, ent.e.rs1, ent.e.rs2, ent.e.rd, ent.e.regWrite, ent.e.memWrite,
                 ent.e.aluSrc, ent.e.branch, ent.e.jump, ent.e.resSrc, ent.e.aluCtl,
                 ent.e.pc, ent.e.imm}) begin
                bad++;
                $display("FAIL sb_ereg t=%0t got v=%b rd=%0d pc=%h imm=%h want v=%b rd=%0d pc=%h imm=%h",
                         $time, validE, rdE, pcE, immExtE, ent.e.valid, ent.e.rd, ent.e.pc, ent.e.imm);
            end
            total++;
            if ({stallCnt, flushCnt} !== {ent.sc, ent.fc}) begin
                bad++;
                $display("FAIL sb_counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, stallCnt, flushCnt, ent.sc, ent.fc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Drive decode fields; unlisted controls and data are randomized
    task automatic setD(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [1:0] rs, input logic as);
        validD      = v;
        rs1D        = r1;
        rs2D        = r2;
        rdD         = rd;
        ResultSrcD  = rs;
        ALUSrcD     = as;
        RegWriteD   = (rd != 5'd0);
        MemWriteD   = 1'($urandom_range(0, 1));
        BranchD     = 1'($urandom_range(0, 1));
        JumpD       = 1'($urandom_range(0, 1));
        ALUControlD = 3'($urandom_range(0, 7));
        rd1D        = $urandom;
        rd2D        = $urandom;
        immExtD     = $urandom;
        pcD         = $urandom;
        #1;
    endtask

    // Predict next ID/EX contents, push them, then advance one clock
    task automatic cycle();
        eT    nxt;
        sbT   s;
        logic lw;
        lw = (modelE.resSrc == 2'b01) && modelE.valid && (modelE.rd != 5'd0)
             && ((modelE.rd == rs1D) || (modelE.rd == rs2D)) && !PCSrcE;
        if (reset || lw || PCSrcE) nxt = '0;
        else nxt = '{valid: validD, rs1: rs1D, rs2: rs2D, rd: rdD, regWrite: RegWriteD,
                     memWrite: MemWriteD, aluSrc: ALUSrcD, branch: BranchD, jump: JumpD,
                     resSrc: ResultSrcD, aluCtl: ALUControlD, pc: pcD, imm: immExtD,
                     rd1: rd1D, rd2: rd2D};
        if (reset) begin
            expSc = '0;
            expFc = '0;
        end else begin
            if (lw && expSc != 32'hFFFF_FFFF)     expSc = expSc + 32'd1;
            if (PCSrcE && expFc != 32'hFFFF_FFFF) expFc = expFc + 32'd1;
        end
        s.e  = nxt;
        s.sc = PERF ? expSc : 32'd0;
        s.fc = PERF ? expFc : 32'd0;
        sb.push_back(s);
        @(posedge clk);
        modelE = nxt;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCSrcE = 1'b0; forwardAE = FWD_RF; forwardBE = FWD_RF;
        ALUResultM = '0; ResultW = '0;
        setD(1'b1, 5'd1, 5'd2, 5'd3, RES_ALU, 1'b0);
        cycle();
        cycle();
        total++;
        if ({stallF, stallD, flushD} !== 3'b000) begin
            bad++; $display("FAIL reset_hazards got=%b want=000", {stallF, stallD, flushD});
        end
        reset = 1'b0;
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        total++;
        if ({stallF, stallD, flushD} !== 3'b000) begin
            bad++; $display("FAIL reset_after got=%b want=000", {stallF, stallD, flushD});
        end
        cycle();
    endtask

    task automatic test_load_use();
        logic [31:0] addRd2;
        setD(1'b1, 5'd2, 5'd0, 5'd5, RES_LOAD, 1'b1);   // lw x5,0(x2)
        cycle();
        setD(1'b1, 5'd5, 5'd1, 5'd6, RES_ALU, 1'b0);    // add x6,x5,x1
        addRd2 = rd2D;
        total++;
        if ({stallF, stallD, flushD} !== 3'b110) begin
            bad++; $display("FAIL lu_hazard got=%b want=110", {stallF, stallD, flushD});
        end
        total++;
        if (SrcBE !== modelE.imm) begin
            bad++; $display("FAIL lu_srcb_imm got=%h want=%h", SrcBE, modelE.imm);
        end
        total++;
        if (SrcAE !== modelE.rd1) begin
            bad++; $display("FAIL lu_srca_rf got=%h want=%h", SrcAE, modelE.rd1);
        end
        cycle();                                        // bubble, decode held
        total++;
        if ({validE, stallF, stallD, flushD} !== 4'b0000) begin
            bad++; $display("FAIL lu_bubble got=%b want=0000", {validE, stallF, stallD, flushD});
        end
        cycle();                                        // add enters EX
        forwardAE = FWD_WB; ResultW = $urandom; ALUResultM = $urandom;
        #1;
        total++;
        if (SrcAE !== ResultW) begin
            bad++; $display("FAIL lu_srca_wb got=%h want=%h", SrcAE, ResultW);
        end
        total++;
        if ({WriteDataE, SrcBE} !== {addRd2, addRd2}) begin
            bad++; $display("FAIL lu_srcb_rf got=%h/%h want=%h", WriteDataE, SrcBE, addRd2);
        end
        forwardAE = FWD_RF;
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        cycle();
    endtask

    task automatic test_forward_mem();
        setD(1'b1, 5'd1, 5'd2, 5'd5, RES_ALU, 1'b0);    // add x5,x1,x2
        cycle();
        setD(1'b1, 5'd5, 5'd5, 5'd7, RES_ALU, 1'b0);    // sub x7,x5,x5
        total++;
        if ({stallF, stallD, flushD} !== 3'b000) begin
            bad++; $display("FAIL fm_no_stall got=%b want=000", {stallF, stallD, flushD});
        end
        cycle();
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        forwardAE = FWD_MEM; forwardBE = FWD_MEM; ALUResultM = $urandom; ResultW = $urandom;
        #1;
        total++;
        if ({SrcAE, WriteDataE, SrcBE} !== {ALUResultM, ALUResultM, ALUResultM}) begin
            bad++; $display("FAIL fm_mem got=%h/%h/%h want=%h", SrcAE, WriteDataE, SrcBE, ALUResultM);
        end
        forwardAE = 2'b11; forwardBE = 2'b11;
        #1;
        total++;
        if ({SrcAE, WriteDataE} !== {modelE.rd1, modelE.rd2}) begin
            bad++; $display("FAIL fm_sel11 got=%h/%h want=%h/%h", SrcAE, WriteDataE, modelE.rd1, modelE.rd2);
        end
        forwardAE = FWD_RF; forwardBE = FWD_RF;
        cycle();
    endtask

    task automatic test_flush_priority();
        setD(1'b1, 5'd2, 5'd0, 5'd5, RES_LOAD, 1'b1);
        cycle();
        setD(1'b1, 5'd5, 5'd1, 5'd6, RES_ALU, 1'b0);
        PCSrcE = 1'b1;
        #1;
        total++;
        if ({stallF, stallD, flushD} !== 3'b001) begin
            bad++; $display("FAIL fl_priority got=%b want=001", {stallF, stallD, flushD});
        end
        cycle();
        PCSrcE = 1'b0;
        #1;
        total++;
        if ({validE, stallF, flushD} !== 3'b000) begin
            bad++; $display("FAIL fl_bubble got=%b want=000", {validE, stallF, flushD});
        end
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        cycle();
    endtask

    task automatic test_x0_load();
        setD(1'b1, 5'd2, 5'd0, 5'd0, RES_LOAD, 1'b1);   // load into x0
        cycle();
        setD(1'b1, 5'd0, 5'd0, 5'd8, RES_ALU, 1'b0);    // reads x0
        total++;
        if ({stallF, stallD, flushD} !== 3'b000) begin
            bad++; $display("FAIL x0_no_stall got=%b want=000", {stallF, stallD, flushD});
        end
        cycle();
        total++;
        if ({validE, rdE} !== {1'b1, 5'd8}) begin
            bad++; $display("FAIL x0_use_in_ex got=%b/%0d want=1/8", validE, rdE);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pr1 [4];
        logic [4:0] prd [4];
        int   idx;
        int   cycles;
        int   stalls;
        logic held;
        pr1 = '{5'd3, 5'd1, 5'd2, 5'd3};                 // lw x1; lw x2,(x1); lw x3,(x2); add x4,x3
        prd = '{5'd1, 5'd2, 5'd3, 5'd4};
        idx = 0; cycles = 0; stalls = 0; held = 1'b0;
        while (idx < 4 && cycles < 20) begin
            if (!held) setD(1'b1, pr1[idx], 5'd0, prd[idx], (idx < 3) ? RES_LOAD : RES_ALU, idx < 3);
            else #1;
            held = stallF;
            if (stallF) stalls++;
            else idx++;
            cycle();
            cycles++;
        end
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        cycle();
        total++;
        if (stalls != 3) begin
            bad++; $display("FAIL b2b_stalls got=%0d want=3", stalls);
        end
        total++;
        if (cycles != 7) begin
            bad++; $display("FAIL b2b_cycles got=%0d want=7", cycles);
        end
    endtask

    task automatic test_reset_mid_stall();
        setD(1'b1, 5'd2, 5'd0, 5'd9, RES_LOAD, 1'b1);
        cycle();
        setD(1'b1, 5'd9, 5'd0, 5'd10, RES_ALU, 1'b0);
        total++;
        if (stallF !== 1'b1) begin
            bad++; $display("FAIL rs_stall_seen got=%b want=1", stallF);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        total++;
        if ({validE, rdE, pcE, immExtE, stallCnt, stallF, flushD} !== '0) begin
            bad++; $display("FAIL rs_cleared got v=%b rd=%0d pc=%h stallCnt=%0d stallF=%b want all 0",
                            validE, rdE, pcE, stallCnt, stallF);
        end
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        cycle();
    endtask

    task automatic test_counters();
        for (int k = 0; k < 3; k++) begin
            setD(1'b1, 5'd2, 5'd0, 5'd5, RES_LOAD, 1'b1);
            cycle();
            setD(1'b1, 5'd5, 5'd0, 5'd6, RES_ALU, 1'b0);
            cycle();
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
            PCSrcE = 1'b1;
            cycle();
            PCSrcE = 1'b0;
        end
        setD(1'b0, 5'd0, 5'd0, 5'd0, RES_ALU, 1'b0);
        cycle();
        total++;
        if ({stallCnt, flushCnt} !== (PERF ? {32'd3, 32'd2} : 64'd0)) begin
            bad++; $display("FAIL cnt_totals got stall=%0d flush=%0d want stall=%0d flush=%0d",
                            stallCnt, flushCnt, PERF ? 3 : 0, PERF ? 2 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward_mem();
        test_flush_priority();
        test_x0_load();
        test_back_to_back();
        test_reset_mid_stall();
        test_counters();
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  validD  in  1  decode slot holds a real instruction
  rs1D, rs2D, rdD  in  5 each  decode register indices
  rd1D, rd2D, immExtD, pcD  in  XLEN each  register-file reads, immediate, PC
  RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD  in  1 each  decode controls
  ResultSrcD  in  2  writeback select; 2'b01 = load
  ALUControlD  in  3  ALU operation
  PCSrcE  in  1  taken branch/jump resolved in EX
  forwardAE, forwardBE  in  2 each  forwarding selects from the forwarding unit
  ALUResultM, ResultW  in  XLEN each  forwarded values
  rs1E, rs2E, rdE  out  5 each  registered indices; feed forwarding unit
  validE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each  registered controls
  ResultSrcE  out  2  registered writeback select
  ALUControlE  out  3  registered ALU operation
  pcE, immExtE  out  XLEN each  registered PC and immediate
  SrcAE, SrcBE, WriteDataE  out  XLEN each  ALU operands, store data
  stallF, stallD, flushD  out  1 each  hazard controls to the front end
  stallCnt, flushCnt  out  32 each  performance counters (REQ-017)

Function
REQ-003 ID/EX register SHALL load all D-side fields on every rising edge unless bubbled or reset.
REQ-004 lwStall SHALL be 1 iff ResultSrcE==2'b01, validE==1, rdE!=0, and (rdE==rs1D or rdE==rs2D), and PCSrcE==0.
REQ-005 stallF and stallD SHALL equal lwStall; flushD SHALL equal PCSrcE.
REQ-006 Bubble condition SHALL be lwStall or PCSrcE; on a bubble the register SHALL load all-zero, so validE=0 and RegWriteE=0.
REQ-007 PCSrcE and a load-use match in the same cycle: PCSrcE SHALL win; lwStall=0, flushD=1, one bubble inserted.
REQ-008 validD=0 SHALL be captured as-is; controls are passed through without gating.
REQ-009 Operand A selection SHALL be combinational from registered state: 00 -> rd1E, 01 -> ALUResultM, 10 -> ResultW, 11 -> rd1E.
REQ-010 WriteDataE SHALL use the same selection with forwardBE over rd2E.
REQ-011 SrcBE SHALL equal immExtE when ALUSrcE=1, else WriteDataE.
REQ-012 Load-use latency: exactly one bubble per load-use hazard; a dependent instruction enters EX two cycles after the load.
REQ-013 Back-to-back loads, each feeding the next, SHALL each produce one bubble; no lost or duplicated instruction.

Reset
REQ-014 Reset SHALL be synchronous: while reset=1 at a clock edge, all E outputs and counters SHALL clear to 0.
REQ-015 stallF, stallD and flushD SHALL read 0 in the cycle after reset, since validE=0.
REQ-016 Reset asserted mid-stall SHALL override the stall: the register SHALL clear and no bubble accounting SHALL occur that cycle.

Configuration
REQ-017 With PERF_CNT_EN defined, stallCnt SHALL increment on each lwStall cycle and flushCnt on each PCSrcE cycle; both SHALL saturate at 32'hFFFFFFFF.
REQ-018 Without PERF_CNT_EN, stallCnt and flushCnt SHALL be constant 0 and no counter flops SHALL be synthesized.

Structure
REQ-019 Shared package SHALL hold the ResultSrc encodings (RES_ALU=00, RES_LOAD=01, RES_PC4=10) and the forward-select encodings (FWD_RF=00, FWD_MEM=01, FWD_WB=10).
REQ-020 The operand multiplexer SHALL be one sub-module, fwd_mux3, instantiated twice (A and B).

Verification
REQ-021 lw x5 followed by add x6,x5,x1 -> stallF=stallD=1 for exactly one cycle, validE=0 bubble, then add in EX with forwardAE=10 and SrcAE=ResultW.
REQ-022 add x5 followed by sub x7,x5,x5 -> no stall; forwardAE=forwardBE=01; SrcAE=WriteDataE=ALUResultM.
REQ-023 PCSrcE=1 with a simultaneous load-use match -> lwStall=0, flushD=1, next validE=0.
REQ-024 Load with rdE=0 followed by a use of x0 -> no stall.
REQ-025 reset=1 during a stall cycle -> next cycle all E outputs 0; stallCnt=0 with PERF_CNT_EN.
REQ-026 With PERF_CNT_EN, 3 load-use hazards and 2 taken branches -> stallCnt=3, flushCnt=2.
